// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit-queue FSM encoding and common widths/rates.
package uart_pkg;

  typedef enum logic [1:0] {
    TQ_IDLE      = 2'd0,
    TQ_LAUNCH    = 2'd1,
    TQ_WAIT_DONE = 2'd2
  } tq_state_t;

  localparam int UART_DATA_W           = 8;
  localparam int CLKS_PER_BIT_9600_50M = 5208;

endpackage

// File: rtl/uart_tx_queue_if.sv
// Push side (capture logic -> queue) and launch side (queue <-> uart_tx) of the transmit queue.
interface uart_tx_queue_if #(
  parameter int WIDTH = 8
);

  // Push: push_valid is a one-cycle strobe with no ready; a push while full is dropped and flagged.
  // Launch: o_Tx_DV is a one-cycle strobe issued only while i_Tx_Active is low, with o_Tx_Byte held
  // from that strobe until the next launch; i_Tx_Done is the one-cycle end-of-frame pulse.
  logic             push_valid;
  logic [WIDTH-1:0] push_data;
  logic             i_Tx_Active;
  logic             i_Tx_Done;
  logic             o_Tx_DV;
  logic [WIDTH-1:0] o_Tx_Byte;

  modport slave (
    input  push_valid, push_data, i_Tx_Active, i_Tx_Done,
    output o_Tx_DV, o_Tx_Byte
  );

  modport master (
    output push_valid, push_data, i_Tx_Active, i_Tx_Done,
    input  o_Tx_DV, o_Tx_Byte
  );

endinterface

// File: rtl/uart_tx_queue_fifo.sv
// Synchronous FIFO with registered occupancy flags and a sticky overflow flag.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             ovf_clear,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             overflow_q, overflow_d;
  logic             push_ok, pop_ok;

  // Acceptance uses the registered flags, so a push into a full queue is dropped even if a pop
  // frees a slot on the same edge.
  assign push_ok = push && !full_q;
  assign pop_ok  = pop && !empty_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    empty_d = (count_d == CW'(0));
    full_d  = (count_d == CW'(DEPTH));
    if (push && full_q)  overflow_d = 1'b1;
    else if (ovf_clear)  overflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
    end
  end

  assign rd_data  = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign empty    = empty_q;
  assign full     = full_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_queue.sv
// Transmit byte queue: buffers captured switch values and launches them one frame at a time into uart_tx.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = UART_DATA_W,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              ovf_clear,
  uart_tx_queue_if.slave    q_if,
  output logic [CW-1:0]     count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output tq_state_t         dbg_state
);

  localparam logic [1:0] S_IDLE      = 2'(TQ_IDLE);
  localparam logic [1:0] S_LAUNCH    = 2'(TQ_LAUNCH);
  localparam logic [1:0] S_WAIT_DONE = 2'(TQ_WAIT_DONE);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] tx_byte_q, tx_byte_d;
  logic [WIDTH-1:0] fifo_rd_data;
  logic             pop_go;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (q_if.push_valid),
    .push_data (q_if.push_data),
    .pop       (pop_go),
    .ovf_clear (ovf_clear),
    .rd_data   (fifo_rd_data),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow)
  );

  assign pop_go = (state_q == S_IDLE) && enable && !empty && !q_if.i_Tx_Active;

  // Losing enable mid-frame abandons the popped byte; the rest of the queue stays put.
  always_comb begin
    state_d   = state_q;
    tx_byte_d = tx_byte_q;
    case (state_q)
      S_IDLE: begin
        if (pop_go) begin
          state_d   = S_LAUNCH;
          tx_byte_d = fifo_rd_data;
        end
      end
      S_LAUNCH:    state_d = enable ? S_WAIT_DONE : S_IDLE;
      S_WAIT_DONE: if (!enable || q_if.i_Tx_Done) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      tx_byte_q <= '0;
    end else begin
      state_q   <= state_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  assign q_if.o_Tx_DV   = (state_q == S_LAUNCH) && enable;
  assign q_if.o_Tx_Byte = tx_byte_q;
  assign dbg_state      = tq_state_t'(state_q);

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue against a behavioural uart_tx with 16 clocks per bit.
module tb_uart_tx_queue;
  import uart_pkg::*;

  localparam int DEPTH = 8;
  localparam int W     = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int FRAME = 10 * 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          ovf_clear;
  logic [CW-1:0] count;
  logic          empty, full, overflow;
  tq_state_t     dbg_state;

  uart_tx_queue_if #(.WIDTH(W)) q_if ();

  uart_tx_queue #(.DEPTH(DEPTH), .WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .ovf_clear (ovf_clear),
    .q_if      (q_if),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // behavioural uart_tx
  logic tx_act, tx_done, force_busy;
  int   tx_cnt;
  assign q_if.i_Tx_Active = tx_act | force_busy;
  assign q_if.i_Tx_Done   = tx_done;

  always @(posedge clk) begin
    if (reset) begin
      tx_act  <= 1'b0;
      tx_done <= 1'b0;
      tx_cnt  <= 0;
    end else begin
      tx_done <= 1'b0;
      if (!tx_act) begin
        if (q_if.o_Tx_DV) begin
          tx_act <= 1'b1;
          tx_cnt <= 0;
        end
      end else if (tx_cnt == FRAME - 1) begin
        tx_act  <= 1'b0;
        tx_done <= 1'b1;
      end else begin
        tx_cnt <= tx_cnt + 1;
      end
    end
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_asserts = 0;
  int n_fail    = 0;
  int dv_pulses = 0;
  logic dv_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (q_if.o_Tx_DV === 1'b1) begin
        dv_pulses++;
        check("dv_single_cycle", dv_prev, 0);
        check("dv_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("tx_byte_order", q_if.o_Tx_Byte, exp_q.pop_front());
      end
      dv_prev = (q_if.o_Tx_DV === 1'b1);
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [W-1:0] b, input bit accept);
    q_if.push_valid = 1'b1;
    q_if.push_data  = b;
    if (accept) exp_q.push_back(b);
    tick(1);
    q_if.push_valid = 1'b0;
  endtask

  task automatic wait_state(input tq_state_t s, input int budget, input string tag);
    int n = 0;
    while (dbg_state !== s && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, dbg_state, s);
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n = 0;
    while (!(exp_q.size() == 0 && !tx_act && dbg_state == TQ_IDLE) && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, exp_q.size(), 0);
    check({tag, "_count"}, count, 0);
    check({tag, "_empty"}, empty, 1);
  endtask

  initial begin
    int pulses;
    reset           = 1'b1;
    enable          = 1'b0;
    ovf_clear       = 1'b0;
    force_busy      = 1'b0;
    q_if.push_valid = 1'b0;
    q_if.push_data  = '0;
    tick(3);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_dv", q_if.o_Tx_DV, 0);
    check("rst_byte", q_if.o_Tx_Byte, 0);
    check("rst_state", dbg_state, TQ_IDLE);
    reset = 1'b0;
    enable = 1'b1;
    tick(1);

    // 1: single byte latency
    push(8'hA5, 1);
    check("t1_count_after_push", count, 1);
    check("t1_dv_early", q_if.o_Tx_DV, 0);
    tick(1);
    check("t1_dv", q_if.o_Tx_DV, 1);
    check("t1_byte", q_if.o_Tx_Byte, 8'hA5);
    check("t1_count_after_pop", count, 0);
    check("t1_empty", empty, 1);
    tick(1);
    check("t1_dv_low", q_if.o_Tx_DV, 0);
    check("t1_wait_done", dbg_state, TQ_WAIT_DONE);
    wait_drain(400, "t1_drain");
    check("t1_byte_held", q_if.o_Tx_Byte, 8'hA5);

    // 2 + 6: fill while busy, overflow and its clear
    force_busy = 1'b1;
    pulses = dv_pulses;
    for (int i = 1; i <= 8; i++) push(W'(i), 1);
    check("t2_full", full, 1);
    check("t2_count", count, 8);
    check("t2_no_ovf", overflow, 0);
    push(8'h09, 0);
    check("t2_overflow", overflow, 1);
    check("t2_count_held", count, 8);
    ovf_clear = 1'b1;
    push(8'h0A, 0);
    check("t6_set_wins", overflow, 1);
    tick(1);
    ovf_clear = 1'b0;
    check("t6_cleared", overflow, 0);
    check("t2_no_launch_busy", dv_pulses, pulses);
    force_busy = 1'b0;
    wait_drain(3000, "t2_drain");
    check("t2_pulses", dv_pulses, pulses + 8);

    // 3: interleaved pushes, pointer wrap
    pulses = dv_pulses;
    for (int i = 0; i < 12; i++) begin
      push(W'($urandom_range(0, 255)), 1);
      check("t3_count_le8", count <= CW'(DEPTH), 1);
      tick($urandom_range(60, 100));
    end
    wait_drain(4000, "t3_drain");
    check("t3_pulses", dv_pulses, pulses + 12);
    check("t3_no_ovf", overflow, 0);

    // 4: enable gating
    enable = 1'b0;
    pulses = dv_pulses;
    push(8'h3C, 1);
    push(8'h3D, 1);
    tick(20);
    check("t4_no_dv_disabled", dv_pulses, pulses);
    check("t4_count2", count, 2);
    enable = 1'b1;
    wait_state(TQ_LAUNCH, 10, "t4_launch");
    tick(1);
    check("t4_wait_done", dbg_state, TQ_WAIT_DONE);
    tick(5);
    enable = 1'b0;
    tick(1);
    check("t4_idle_on_disable", dbg_state, TQ_IDLE);
    check("t4_retained", count, 1);
    for (int n = 0; n < 300 && tx_act; n++) tick(1);
    tick(5);
    check("t4_still_retained", count, 1);
    check("t4_one_sent", dv_pulses, pulses + 1);
    enable = 1'b1;
    wait_drain(400, "t4_drain");
    check("t4_two_sent", dv_pulses, pulses + 2);

    // 5: reset mid-frame
    push(8'h11, 1);
    push(8'h22, 1);
    push(8'h33, 1);
    push(8'h44, 1);
    check("t5_count3", count, 3);
    check("t5_wait_done", dbg_state, TQ_WAIT_DONE);
    reset = 1'b1;
    tick(1);
    exp_q.delete();
    check("t5_count", count, 0);
    check("t5_empty", empty, 1);
    check("t5_dv", q_if.o_Tx_DV, 0);
    check("t5_overflow", overflow, 0);
    check("t5_state", dbg_state, TQ_IDLE);
    reset = 1'b0;
    pulses = dv_pulses;
    tick(200);
    check("t5_nothing_sent", dv_pulses, pulses);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
